// File: rtl/led_matrix_scroller.sv
// Scrolls a buffered character message right-to-left across an 8x8 LED matrix,
// one glyph column per scroll step, followed by eight blank columns.
module led_matrix_scroller #(
   parameter int MSG_DEPTH = 16,
   parameter int DIV_W     = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [7:0]                   wr_data,
   input  logic                         clear,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         loop,
   input  logic [DIV_W-1:0]             step_div,
   input  logic [63:0]                  glyph,
   output logic [7:0]                   char_code,
   output logic [63:0]                  frame,
   output logic                         busy,
   output logic                         done,
   output logic                         full,
   output logic [$clog2(MSG_DEPTH):0]   msg_len
);

   localparam int AW = $clog2(MSG_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] ONE     = LW'(1);
   localparam logic [LW-1:0] DEPTH_L = LW'(MSG_DEPTH);

   typedef enum logic [1:0] {IDLE, SCROLL, FLUSH} state_t;

   state_t            state_q;
   logic [7:0]        mem_q [MSG_DEPTH];
   logic [LW-1:0]     msg_len_q;
   logic [AW-1:0]     char_idx_q;
   logic [2:0]        col_q;
   logic [2:0]        flush_q;
   logic [DIV_W-1:0]  presc_q;
   logic [63:0]       frame_q;
   logic [63:0]       frame_d;
   logic              done_q;
   logic [7:0]        in_col;
   logic              tick;
   logic              last_char;
   logic              wr_ok;

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign full      = (msg_len_q == DEPTH_L);
   assign msg_len   = msg_len_q;
   assign frame     = frame_q;
   assign char_code = (state_q == SCROLL) ? mem_q[char_idx_q] : 8'd0;

   // >= rather than == so a step_div lowered mid-count still wraps promptly
   assign tick      = busy && (presc_q >= step_div);
   assign last_char = ({1'b0, char_idx_q} == (msg_len_q - ONE));
   assign wr_ok     = (state_q == IDLE) && wr_en && !full && !clear;

   always_comb begin
      in_col  = '0;
      frame_d = frame_q;
      for (int r = 0; r < 8; r++) begin
         if (state_q == SCROLL) in_col[r] = glyph[{3'(r), col_q}];
         frame_d[8*r +: 7] = frame_q[8*r+1 +: 7];
         frame_d[8*r+7]    = in_col[r];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[msg_len_q[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         msg_len_q  <= '0;
         char_idx_q <= '0;
         col_q      <= '0;
         flush_q    <= '0;
         presc_q    <= '0;
         frame_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear)      msg_len_q <= '0;
               else if (wr_ok) msg_len_q <= msg_len_q + ONE;
               if (start && !clear && (msg_len_q != '0)) begin
                  state_q    <= SCROLL;
                  char_idx_q <= '0;
                  col_q      <= '0;
                  flush_q    <= '0;
                  presc_q    <= '0;
                  frame_q    <= '0;
               end
            end
            SCROLL, FLUSH: begin
               if (stop) begin
                  // frame is deliberately left frozen on abort
                  state_q    <= IDLE;
                  char_idx_q <= '0;
                  col_q      <= '0;
                  flush_q    <= '0;
                  presc_q    <= '0;
               end else if (tick) begin
                  presc_q <= '0;
                  frame_q <= frame_d;
                  if (state_q == SCROLL) begin
                     col_q <= col_q + 3'd1;
                     if (col_q == 3'd7) begin
                        if (last_char) begin
                           state_q <= FLUSH;
                           flush_q <= '0;
                        end else begin
                           char_idx_q <= char_idx_q + AW'(1);
                        end
                     end
                  end else begin
                     flush_q <= flush_q + 3'd1;
                     if (flush_q == 3'd7) begin
                        char_idx_q <= '0;
                        col_q      <= '0;
                        if (loop) begin
                           state_q <= SCROLL;
                        end else begin
                           state_q <= IDLE;
                           done_q  <= 1'b1;
                        end
                     end
                  end
               end else begin
                  presc_q <= presc_q + DIV_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
